// File: rtl/tank_arbiter_if.sv
// rtl/tank_arbiter_if.sv - request/sensor/grant bundle between tank_arbiter and its environment
//
// master: drives requests, level sensors and clear_fault; observes grants and status.
// slave : the arbiter side.
//   req_rega, req_adb, req_limp : access requests (irrigation, dosing, cleaning)
//   level_low, level_high       : tank level sensors
//   clear_fault                 : single-cycle pulse that leaves FAULT
//   gnt_rega, gnt_adb, gnt_limp : one-hot-or-zero access grants
//   fill_valve                  : inlet valve open
//   fault                       : high while in FAULT
//   state_out                   : current state code
interface tank_arbiter_if;
    logic       req_rega;
    logic       req_adb;
    logic       req_limp;
    logic       level_low;
    logic       level_high;
    logic       clear_fault;
    logic       gnt_rega;
    logic       gnt_adb;
    logic       gnt_limp;
    logic       fill_valve;
    logic       fault;
    logic [2:0] state_out;

    modport master (
        output req_rega, req_adb, req_limp, level_low, level_high, clear_fault,
        input  gnt_rega, gnt_adb, gnt_limp, fill_valve, fault, state_out
    );

    modport slave (
        input  req_rega, req_adb, req_limp, level_low, level_high, clear_fault,
        output gnt_rega, gnt_adb, gnt_limp, fill_valve, fault, state_out
    );
endinterface

// File: rtl/tank_arbiter.sv
// rtl/tank_arbiter.sv - round-robin tank/valve arbiter with fill control and sticky fault
//
// Ports:
//   clock  : rising-edge clock
//   resetN : asynchronous, active-high reset
//   bus    : tank_arbiter_if.slave (requests, sensors, clear_fault in; grants, valve, status out)
// Parameters:
//   FILL_MAX  : cycles allowed in FILL before a fill-timeout fault (clamped to 1..255)
//   GRANT_MAX : cycles any single grant may be held (clamped to 1..255)
module tank_arbiter #(
    parameter int FILL_MAX  = 200,
    parameter int GRANT_MAX = 100
) (
    input  logic           clock,
    input  logic           resetN,
    tank_arbiter_if.slave  bus
);

    typedef enum logic [2:0] {
        IDLE   = 3'b000,
        FILL   = 3'b001,
        G_REGA = 3'b010,
        G_ADB  = 3'b011,
        G_LIMP = 3'b100,
        FAULT  = 3'b101
    } state_t;

    localparam int FILL_LIM  = (FILL_MAX  < 1) ? 1 : ((FILL_MAX  > 255) ? 255 : FILL_MAX);
    localparam int GRANT_LIM = (GRANT_MAX < 1) ? 1 : ((GRANT_MAX > 255) ? 255 : GRANT_MAX);
    // The counter reads 0 in the first cycle of a state, so the last allowed
    // cycle is the one where it equals LIM-1.
    localparam logic [7:0] FILL_END  = 8'(FILL_LIM - 1);
    localparam logic [7:0] GRANT_END = 8'(GRANT_LIM - 1);

    state_t     state;
    state_t     state_nxt;
    logic [7:0] cnt;
    logic [1:0] last;       // last granted requester: 0 rega, 1 adb, 2 limp
    logic [1:0] last_nxt;
    logic [1:0] pick;       // next requester in round-robin order
    logic [2:0] req;
    logic       conflict;

    assign req      = {bus.req_limp, bus.req_adb, bus.req_rega};
    assign conflict = bus.level_low & bus.level_high;

    // Search starts just after the last granted requester.
    always_comb begin
        pick = 2'd0;
        case (last)
            2'd0:    pick = req[1] ? 2'd1 : (req[2] ? 2'd2 : 2'd0);
            2'd1:    pick = req[2] ? 2'd2 : (req[0] ? 2'd0 : 2'd1);
            default: pick = req[0] ? 2'd0 : (req[1] ? 2'd1 : 2'd2);
        endcase
    end

    always_comb begin
        state_nxt = state;
        last_nxt  = last;
        case (state)
            IDLE: begin
                if (conflict)
                    state_nxt = FAULT;
                else if (bus.level_low)
                    state_nxt = FILL;
                else if (|req) begin
                    // Grant states are only ever entered from here, so this is
                    // the single place the pointer moves.
                    last_nxt = pick;
                    case (pick)
                        2'd0:    state_nxt = G_REGA;
                        2'd1:    state_nxt = G_ADB;
                        default: state_nxt = G_LIMP;
                    endcase
                end
            end
            FILL: begin
                if (conflict)
                    state_nxt = FAULT;
                else if (bus.level_high)
                    state_nxt = IDLE;
                else if (cnt >= FILL_END)
                    state_nxt = FAULT;
            end
            G_REGA: begin
                if (conflict)
                    state_nxt = FAULT;
                else if (bus.level_low)
                    state_nxt = FILL;
                else if (!bus.req_rega || cnt >= GRANT_END)
                    state_nxt = IDLE;
            end
            G_ADB: begin
                if (conflict)
                    state_nxt = FAULT;
                else if (bus.level_low)
                    state_nxt = FILL;
                else if (!bus.req_adb || cnt >= GRANT_END)
                    state_nxt = IDLE;
            end
            G_LIMP: begin
                // Cleaning drains the tank, so a low level does not abort it.
                if (conflict)
                    state_nxt = FAULT;
                else if (!bus.req_limp || cnt >= GRANT_END)
                    state_nxt = IDLE;
            end
            FAULT: begin
                if (bus.clear_fault)
                    state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge resetN) begin
        if (resetN) begin
            state <= IDLE;
            cnt   <= 8'd0;
            last  <= 2'd2;
        end else begin
            state <= state_nxt;
            last  <= last_nxt;
            if (state_nxt != state)
                cnt <= 8'd0;
            else if ((state == FILL || state == G_REGA || state == G_ADB || state == G_LIMP)
                     && cnt != 8'hFF)
                cnt <= cnt + 8'd1;
        end
    end

    assign bus.gnt_rega   = (state == G_REGA);
    assign bus.gnt_adb    = (state == G_ADB);
    assign bus.gnt_limp   = (state == G_LIMP);
    assign bus.fill_valve = (state == FILL);
    assign bus.fault      = (state == FAULT);
    assign bus.state_out  = state;

endmodule

// File: tb/tb_tank_arbiter.sv
// tb/tb_tank_arbiter.sv - randomized scoreboard bench for tank_arbiter
module tb_tank_arbiter;

    localparam int FILL_MAX  = 200;
    localparam int GRANT_MAX = 100;

    logic clock = 1'b0;
    logic resetN;

    tank_arbiter_if bus ();

    tank_arbiter #(.FILL_MAX(FILL_MAX), .GRANT_MAX(GRANT_MAX)) dut (
        .clock  (clock),
        .resetN (resetN),
        .bus    (bus)
    );

    always #5 clock = ~clock;

    int checks   = 0;
    int failures = 0;

    bit [2:0] exp_q[$];
    bit       mon_en = 1'b0;

    // Reference model: state code, number of cycles spent in it so far,
    // and the index (0 rega, 1 adb, 2 limp) of the requester served last.
    int m_state;
    int m_dwell;
    int m_last;

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [4:0] decode(input bit [2:0] st);
        return {st == 3'd2, st == 3'd3, st == 3'd4, st == 3'd1, st == 3'd5};
    endfunction

    task automatic model_reset();
        m_state = 0;
        m_dwell = 1;
        m_last  = 2;
    endtask

    task automatic model_step(input bit [2:0] req, input bit lo, input bit hi, input bit cl);
        int nxt;
        int own;
        nxt = m_state;
        if (m_state == 5) begin
            if (cl) nxt = 0;
        end else if (m_state > 5) begin
            nxt = 0;
        end else if (lo && hi) begin
            nxt = 5;
        end else if (m_state == 0) begin
            if (lo) nxt = 1;
            else begin
                for (int k = 1; k <= 3; k++) begin
                    if (nxt == 0 && req[(m_last + k) % 3]) nxt = 2 + (m_last + k) % 3;
                end
                if (nxt != 0) m_last = nxt - 2;
            end
        end else if (m_state == 1) begin
            if (hi) nxt = 0;
            else if (m_dwell >= FILL_MAX) nxt = 5;
        end else begin
            own = m_state - 2;
            if (lo && own != 2) nxt = 1;
            else if (!req[own]) nxt = 0;
            else if (m_dwell >= GRANT_MAX) nxt = 0;
        end
        if (nxt != m_state) m_dwell = 1;
        else m_dwell++;
        m_state = nxt;
    endtask

    task automatic drive_step(input bit [2:0] req, input bit lo, input bit hi, input bit cl);
        bus.req_rega    = req[0];
        bus.req_adb     = req[1];
        bus.req_limp    = req[2];
        bus.level_low   = lo;
        bus.level_high  = hi;
        bus.clear_fault = cl;
        model_step(req, lo, hi, cl);
        exp_q.push_back(3'(m_state));
    endtask

    task automatic cycle(input bit [2:0] req, input bit lo, input bit hi, input bit cl);
        @(negedge clock);
        drive_step(req, lo, hi, cl);
    endtask

    // Monitor: compares every post-edge output against the queued expectation.
    initial begin
        bit [2:0] e;
        forever begin
            @(posedge clock);
            #1;
            if (mon_en) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL scoreboard_empty at %0t", $time);
                end else begin
                    e = exp_q.pop_front();
                    check("state_out", {5'd0, bus.state_out}, {5'd0, e});
                    check("decoded_outputs",
                          {3'd0, bus.gnt_rega, bus.gnt_adb, bus.gnt_limp, bus.fill_valve, bus.fault},
                          {3'd0, decode(e)});
                end
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog_timeout at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        bit [2:0] r;
        bit       lo;
        bit       hi;
        bit       cl;
        int       n;

        resetN          = 1'b1;
        bus.req_rega    = 1'b0;
        bus.req_adb     = 1'b0;
        bus.req_limp    = 1'b0;
        bus.level_low   = 1'b0;
        bus.level_high  = 1'b0;
        bus.clear_fault = 1'b0;
        model_reset();
        repeat (3) @(posedge clock);
        #2;
        check("reset_state_out", {5'd0, bus.state_out}, 8'd0);
        check("reset_outputs",
              {3'd0, bus.gnt_rega, bus.gnt_adb, bus.gnt_limp, bus.fill_valve, bus.fault}, 8'd0);

        @(negedge clock);
        resetN = 1'b0;
        mon_en = 1'b1;
        drive_step(3'b111, 1'b0, 1'b0, 1'b0);

        // All three requesters held: rotating full-length grants.
        repeat (320) cycle(3'b111, 1'b0, 1'b0, 1'b0);

        // Fill requested alongside a dosing request; tank fills at cycle 10.
        repeat (3) cycle(3'b000, 1'b0, 1'b0, 1'b0);
        cycle(3'b010, 1'b1, 1'b0, 1'b0);
        repeat (9) cycle(3'b010, 1'b0, 1'b0, 1'b0);
        cycle(3'b010, 1'b0, 1'b1, 1'b0);
        repeat (5) cycle(3'b010, 1'b0, 1'b0, 1'b0);

        // Fill timeout, then clear.
        repeat (2) cycle(3'b000, 1'b0, 1'b0, 1'b0);
        cycle(3'b000, 1'b1, 1'b0, 1'b0);
        repeat (205) cycle(3'b000, 1'b0, 1'b0, 1'b0);
        cycle(3'b111, 1'b0, 1'b0, 1'b1);
        repeat (2) cycle(3'b000, 1'b0, 1'b0, 1'b0);

        // Low level aborts irrigation but not cleaning.
        repeat (3) cycle(3'b001, 1'b0, 1'b0, 1'b0);
        cycle(3'b001, 1'b1, 1'b0, 1'b0);
        repeat (3) cycle(3'b000, 1'b0, 1'b1, 1'b0);
        repeat (3) cycle(3'b100, 1'b0, 1'b0, 1'b0);
        repeat (4) cycle(3'b100, 1'b1, 1'b0, 1'b0);
        repeat (2) cycle(3'b000, 1'b0, 1'b1, 1'b0);

        // Sensor conflict in a dosing grant; FAULT ignores everything but clear.
        repeat (3) cycle(3'b010, 1'b0, 1'b0, 1'b0);
        cycle(3'b010, 1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 12; i++)
            cycle(3'($urandom), 1'($urandom), 1'($urandom), 1'b0);
        cycle(3'b000, 1'b0, 1'b0, 1'b1);
        repeat (2) cycle(3'b000, 1'b0, 1'b0, 1'b0);

        // Randomized traffic with slowly changing requests.
        r = 3'b000;
        for (int i = 0; i < 2000; i++) begin
            for (int b = 0; b < 3; b++)
                if ($urandom_range(15) == 0) r[b] = ~r[b];
            lo = ($urandom_range(9) == 0);
            hi = ($urandom_range(9) == 0);
            cl = ($urandom_range(24) == 0);
            cycle(r, lo, hi, cl);
        end

        // Steer into a cleaning grant, then reset it between edges.
        cycle(3'b100, 1'b0, 1'b1, 1'b1);
        n = 0;
        while (m_state != 4 && n < 10) begin
            cycle(3'b100, 1'b0, 1'b0, 1'b0);
            n++;
        end
        checks++;
        if (m_state != 4) begin
            failures++;
            $display("FAIL reach_g_limp actual=%0d expected=4", m_state);
        end
        cycle(3'b100, 1'b0, 1'b0, 1'b0);
        @(posedge clock);
        #3;
        resetN = 1'b1;
        #1;
        mon_en = 1'b0;
        exp_q.delete();
        check("async_reset_gnt_limp", {7'd0, bus.gnt_limp}, 8'd0);
        check("async_reset_state_out", {5'd0, bus.state_out}, 8'd0);
        @(negedge clock);
        resetN = 1'b0;
        model_reset();
        mon_en = 1'b1;
        drive_step(3'b111, 1'b0, 1'b0, 1'b0);
        @(posedge clock);
        #2;
        mon_en = 1'b0;
        check("post_reset_first_grant_rega", {7'd0, bus.gnt_rega}, 8'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
